// File: rtl/ic_pkg.sv
// Shared I-cache definitions: geometry defaults, refill FSM encoding and the
// helpers that locate index/tag/offset fields in a fetch address. The hit-compare
// logic uses the same helpers so both sides slice the PC identically.
package ic_pkg;

  localparam int IRWIDTH_DEF = 12;  // tag-RAM index width
  localparam int BEATW_DEF   = 2;   // log2 words per line

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_FILL  = 3'd2,
    ST_TAG   = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  // Lowest index bit: just above the byte offset within the line.
  function automatic int idx_lsb(input int beatw);
    return beatw + 2;
  endfunction

  // Lowest tag bit: just above the index field.
  function automatic int tag_lsb(input int irwidth, input int beatw);
    return irwidth + beatw + 2;
  endfunction

  // Stored tag bits (excluding the valid bit); the tag entry is 24-irwidth wide.
  function automatic int tag_bits(input int irwidth);
    return 23 - irwidth;
  endfunction

endpackage

// File: rtl/ic_refill_ctrl.sv
// I-cache refill controller: on an IF miss it invalidates the target tag entry,
// reads one line from the instruction-memory port, streams each beat into the
// data RAM and finally writes {valid,tag}. Optional fence.i sweep is built when
// ICACHE_FLUSH_EN is defined; otherwise flush_req is accepted but ignored.
module ic_refill_ctrl
  import ic_pkg::*;
#(
  parameter int IRWIDTH = IRWIDTH_DEF,
  parameter int BEATW   = BEATW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_req,
  input  logic [31:0]             miss_adr,
  output logic                    refill_busy,
  output logic                    refill_done,
  output logic                    mem_req,
  output logic [31:0]             mem_adr,
  input  logic                    mem_ack,
  input  logic                    mem_rvalid,
  input  logic [31:0]             mem_rdata,
  output logic                    dram_wen,
  output logic [IRWIDTH+BEATW-1:0] dram_wadr,
  output logic [31:0]             dram_wdata,
  output logic                    tag_wen,
  output logic [IRWIDTH-1:0]      tag_wadr,
  output logic [23-IRWIDTH:0]     tag_wdata,
  input  logic                    flush_req
);

  localparam int IDX_LSB = idx_lsb(BEATW);
  localparam int TAGW    = tag_bits(IRWIDTH);
  localparam int LINEW   = 32 - IDX_LSB;
  localparam logic [BEATW-1:0] LAST_BEAT = '1;

  state_e             state_q, state_d;
  logic [LINEW-1:0]   line_q, line_d;     // miss address without the line offset
  logic [BEATW-1:0]   beat_q, beat_d;

`ifdef ICACHE_FLUSH_EN
  logic [IRWIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic               flush_pend_q, flush_pend_d;
  logic               unused_bits;
  assign unused_bits = ^miss_adr[IDX_LSB-1:0];
`else
  logic               unused_bits;
  assign unused_bits = ^{miss_adr[IDX_LSB-1:0], flush_req};
`endif

  logic [LINEW-1:0]   miss_line;
  logic [IRWIDTH-1:0] line_idx;
  logic [TAGW-1:0]    line_tag;

  assign miss_line = miss_adr[31:IDX_LSB];
  assign line_idx  = line_q[IRWIDTH-1:0];
  assign line_tag  = line_q[IRWIDTH+TAGW-1:IRWIDTH];

  // Next-state logic and all RAM/bus outputs; outputs are forced low during reset.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d     = state_q;
    line_d      = line_q;
    beat_d      = beat_q;
`ifdef ICACHE_FLUSH_EN
    flush_cnt_d  = flush_cnt_q;
    flush_pend_d = flush_pend_q;
`endif
    refill_busy = (state_q != ST_IDLE);
    refill_done = 1'b0;
    mem_req     = 1'b0;
    mem_adr     = '0;
    dram_wen    = 1'b0;
    dram_wadr   = '0;
    dram_wdata  = '0;
    tag_wen     = 1'b0;
    tag_wadr    = '0;
    tag_wdata   = '0;

    case (state_q)
      ST_IDLE: begin
`ifdef ICACHE_FLUSH_EN
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end else
`endif
        if (miss_req) begin
          // Invalidate the victim entry now so a partially filled line never hits.
          line_d    = miss_line;
          beat_d    = '0;
          state_d   = ST_REQ;
          tag_wen   = 1'b1;
          tag_wadr  = miss_line[IRWIDTH-1:0];
          tag_wdata = {1'b0, miss_line[IRWIDTH+TAGW-1:IRWIDTH]};
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        mem_adr = {line_q, {IDX_LSB{1'b0}}};
        if (mem_ack) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (mem_rvalid) begin
          dram_wen   = 1'b1;
          dram_wadr  = {line_idx, beat_q};
          dram_wdata = mem_rdata;
          beat_d     = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_TAG;
        end
      end
      ST_TAG: begin
        tag_wen     = 1'b1;
        tag_wadr    = line_idx;
        tag_wdata   = {1'b1, line_tag};
        refill_done = 1'b1;
        state_d     = ST_IDLE;
`ifdef ICACHE_FLUSH_EN
        if (flush_pend_q || flush_req) begin
          state_d      = ST_FLUSH;
          flush_cnt_d  = '0;
          flush_pend_d = 1'b0;
        end
`endif
      end
`ifdef ICACHE_FLUSH_EN
      ST_FLUSH: begin
        tag_wen     = 1'b1;
        tag_wadr    = flush_cnt_q;
        tag_wdata   = '0;
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == '1) begin
          refill_done = 1'b1;
          state_d     = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef ICACHE_FLUSH_EN
    // A fence.i arriving mid-refill waits until the line is complete.
    if (flush_req && (state_q == ST_REQ || state_q == ST_FILL)) flush_pend_d = 1'b1;
`endif

    // Reset aborts at once: no RAM write or bus request in the reset cycle itself.
    if (rst) begin
      refill_busy = 1'b0;
      refill_done = 1'b0;
      mem_req     = 1'b0;
      mem_adr     = '0;
      dram_wen    = 1'b0;
      dram_wadr   = '0;
      dram_wdata  = '0;
      tag_wen     = 1'b0;
      tag_wadr    = '0;
      tag_wdata   = '0;
    end
  end

  // State, latched line address and counters.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: only control state is reset; the RAMs themselves are invalidated by tags, not cleared.
      state_q <= ST_IDLE;
      line_q  <= '0;
      beat_q  <= '0;
`ifdef ICACHE_FLUSH_EN
      flush_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
`ifdef ICACHE_FLUSH_EN
      flush_cnt_q  <= flush_cnt_d;
      flush_pend_q <= flush_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_ic_refill_ctrl.sv
// Self-checking bench for ic_refill_ctrl. Expected RAM writes are pushed to
// queues as stimulus is driven; a negedge monitor records what the DUT writes
// and each scenario pops and compares. Define ICACHE_FLUSH_EN to also run the
// fence.i sweep scenario (bench then uses IRWIDTH=4).
module tb_ic_refill_ctrl;

`ifdef ICACHE_FLUSH_EN
  localparam int IRW = 4;
`else
  localparam int IRW = 12;
`endif
  localparam int TAGW = 23 - IRW;

  typedef struct packed { logic [IRW+1:0] a; logic [31:0] d; } dw_t;
  typedef struct packed { logic [IRW-1:0] a; logic [TAGW:0] d; } tw_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              miss_req = 1'b0;
  logic [31:0]       miss_adr = '0;
  logic              refill_busy, refill_done, mem_req;
  logic [31:0]       mem_adr;
  logic              mem_ack = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [31:0]       mem_rdata = '0;
  logic              dram_wen;
  logic [IRW+1:0]    dram_wadr;
  logic [31:0]       dram_wdata;
  logic              tag_wen;
  logic [IRW-1:0]    tag_wadr;
  logic [TAGW:0]     tag_wdata;
  logic              flush_req = 1'b0;

  ic_refill_ctrl #(.IRWIDTH(IRW), .BEATW(2)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_adr(miss_adr),
    .refill_busy(refill_busy), .refill_done(refill_done),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dram_wen(dram_wen), .dram_wadr(dram_wadr), .dram_wdata(dram_wdata),
    .tag_wen(tag_wen), .tag_wadr(tag_wadr), .tag_wdata(tag_wdata),
    .flush_req(flush_req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records DUT writes and refill_done events (only this block writes these).
  dw_t obs_d[$];
  tw_t obs_t[$];
  int  done_cnt = 0;
  int  done_cyc = 0;
  logic [IRW-1:0] done_adr = '0;
  int  flush_start_cyc = -1;
  always @(negedge clk) begin
    if (dram_wen) obs_d.push_back('{a: dram_wadr, d: dram_wdata});
    if (tag_wen)  obs_t.push_back('{a: tag_wadr, d: tag_wdata});
    if (refill_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      done_adr = tag_wadr;
    end
    if (tag_wen && refill_busy && tag_wadr == '0 && tag_wdata == '0) flush_start_cyc = cyc;
  end

  // Scoreboard state (owned by the initial block).
  dw_t exp_d[$];
  tw_t exp_t[$];
  int  rd_d = 0, rd_t = 0;
  int  total = 0, bad = 0;

  function automatic logic [IRW-1:0] idx_of(input logic [31:0] adr);
    logic [31:0] s;
    s = adr >> 4;
    return s[IRW-1:0];
  endfunction

  function automatic logic [TAGW-1:0] tag_of(input logic [31:0] adr);
    logic [31:0] s;
    s = adr >> (IRW + 4);
    return s[TAGW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full refill with configurable ack wait, beat gap and injected noise;
  // compares bus behaviour inline and then drains the scoreboard.
  task automatic run_refill(input logic [31:0] adr, input int ack_wait, input int gap,
                            input logic [31:0] dbase, input bit rv_in_req,
                            input bit miss_in_fill, input bit flush_in_fill);
    int start, d0, tag_cyc, lim;
    dw_t e;
    tw_t t;
    logic [31:0] line;
    line = {adr[31:4], 4'h0};
    exp_t.push_back('{a: idx_of(adr), d: {1'b0, tag_of(adr)}});
    for (int b = 0; b < 4; b++) exp_d.push_back('{a: {idx_of(adr), 2'(b)}, d: dbase + 32'(b)});
    exp_t.push_back('{a: idx_of(adr), d: {1'b1, tag_of(adr)}});
    if (flush_in_fill)
      for (int i = 0; i < (1 << IRW); i++) exp_t.push_back('{a: IRW'(i), d: '0});

    d0 = done_cnt;
    miss_adr = adr;
    miss_req = 1'b1;
    start = cyc;
    step();
    miss_req = 1'b0;
    total++;
    if ({mem_req, mem_adr} !== {1'b1, line}) begin
      bad++;
      $display("FAIL req_issue: got req=%b adr=%h, required req=1 adr=%h", mem_req, mem_adr, line);
    end
    for (int k = 0; k < ack_wait; k++) begin
      mem_rvalid = rv_in_req && (k == 0);
      mem_rdata  = 32'hDEAD_0000;
      step();
      mem_rvalid = 1'b0;
    end
    total++;
    if ({mem_req, mem_adr} !== {1'b1, line}) begin
      bad++;
      $display("FAIL req_held: got req=%b adr=%h, required req=1 adr=%h", mem_req, mem_adr, line);
    end
    mem_ack    = 1'b1;
    mem_rvalid = rv_in_req && (ack_wait == 0);
    mem_rdata  = 32'hDEAD_0001;
    step();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    total++;
    if ({mem_req, refill_busy} !== 2'b01) begin
      bad++;
      $display("FAIL req_drop: got req=%b busy=%b, required req=0 busy=1", mem_req, refill_busy);
    end
    for (int b = 0; b < 4; b++) begin
      if (b == 2) repeat (gap) step();
      mem_rvalid = 1'b1;
      mem_rdata  = dbase + 32'(b);
      miss_req   = miss_in_fill && (b == 1);
      flush_req  = flush_in_fill && (b == 1);
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_0002;
      miss_req   = 1'b0;
      flush_req  = 1'b0;
    end
    step();
    tag_cyc = done_cyc;
    total++;
    if ((done_cnt - d0) !== 1 || (tag_cyc - start) !== 6 + ack_wait + gap) begin
      bad++;
      $display("FAIL done_timing: got pulses=%0d latency=%0d, required pulses=1 latency=%0d",
               done_cnt - d0, tag_cyc - start, 6 + ack_wait + gap);
    end
    if (!flush_in_fill) begin
      total++;
      if (refill_busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_after: got busy=%b, required 0", refill_busy);
      end
    end else begin
      lim = 0;
      while (done_cnt - d0 < 2 && lim < 100) begin
        step();
        lim++;
      end
      total++;
      if (flush_start_cyc !== tag_cyc + 1 || lim >= 100) begin
        bad++;
        $display("FAIL flush_after_tag: got start=%0d waited=%0d, required start=%0d",
                 flush_start_cyc, lim, tag_cyc + 1);
      end
    end
    while (exp_d.size() > 0) begin
      e = exp_d.pop_front();
      total++;
      if (rd_d >= obs_d.size()) begin
        bad++;
        $display("FAIL dram_write: got none, required adr=%h data=%h", e.a, e.d);
      end else begin
        if (obs_d[rd_d] !== e) begin
          bad++;
          $display("FAIL dram_write: got adr=%h data=%h, required adr=%h data=%h",
                   obs_d[rd_d].a, obs_d[rd_d].d, e.a, e.d);
        end
        rd_d++;
      end
    end
    while (exp_t.size() > 0) begin
      t = exp_t.pop_front();
      total++;
      if (rd_t >= obs_t.size()) begin
        bad++;
        $display("FAIL tag_write: got none, required adr=%h data=%h", t.a, t.d);
      end else begin
        if (obs_t[rd_t] !== t) begin
          bad++;
          $display("FAIL tag_write: got adr=%h data=%h, required adr=%h data=%h",
                   obs_t[rd_t].a, obs_t[rd_t].d, t.a, t.d);
        end
        rd_t++;
      end
    end
    total++;
    if (obs_d.size() != rd_d || obs_t.size() != rd_t) begin
      bad++;
      $display("FAIL extra_writes: got dram=%0d tag=%0d surplus, required 0 and 0",
               obs_d.size() - rd_d, obs_t.size() - rd_t);
    end
    rd_d = obs_d.size();
    rd_t = obs_t.size();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    miss_adr = 32'h0000_1234;
    repeat (3) step();
    total++;
    if ({refill_busy, refill_done, mem_req, mem_adr, dram_wen, dram_wadr, dram_wdata,
         tag_wen, tag_wadr, tag_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b req=%b dwen=%b twen=%b, required all zero",
               refill_busy, mem_req, dram_wen, tag_wen);
    end
    rst = 1'b0;
    step();
    total++;
    if (refill_busy !== 1'b0 || obs_d.size() != 0 || obs_t.size() != 0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b writes=%0d, required busy=0 writes=0",
               refill_busy, obs_d.size() + obs_t.size());
    end
  endtask

  task automatic test_basic();
    run_refill(32'h0000_1234, 0, 0, 32'h0000_00A0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ack_gap();
    run_refill(32'h0000_1234, 5, 3, 32'h0000_00B0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored();
    int n0;
    n0 = obs_d.size();
    run_refill(32'h0ABC_DEF8, 2, 0, 32'h1234_5670, 1'b1, 1'b1, 1'b0);
    total++;
    if (obs_d.size() - n0 != 4) begin
      bad++;
      $display("FAIL ignored_count: got %0d dram writes, required 4", obs_d.size() - n0);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] adr;
    adr = 32'h0000_5670;
    exp_t.push_back('{a: idx_of(adr), d: {1'b0, tag_of(adr)}});
    for (int b = 0; b < 2; b++) exp_d.push_back('{a: {idx_of(adr), 2'(b)}, d: 32'hC0 + 32'(b)});
    miss_adr = adr;
    miss_req = 1'b1;
    step();
    miss_req = 1'b0;
    mem_ack  = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hC0 + 32'(b);
      step();
    end
    rst = 1'b1;
    mem_rdata = 32'hC2;
    #1;
    total++;
    if ({dram_wen, tag_wen, refill_busy} !== 3'b000) begin
      bad++;
      $display("FAIL abort_in_reset: got dwen=%b twen=%b busy=%b, required all 0",
               dram_wen, tag_wen, refill_busy);
    end
    step();
    rst = 1'b0;
    mem_rdata = 32'hC3;
    #1;
    total++;
    if ({refill_busy, refill_done, mem_req, mem_adr, dram_wen, dram_wadr, dram_wdata,
         tag_wen, tag_wadr, tag_wdata} !== '0) begin
      bad++;
      $display("FAIL abort_after: got busy=%b req=%b dwen=%b twen=%b, required all zero",
               refill_busy, mem_req, dram_wen, tag_wen);
    end
    step();
    mem_rvalid = 1'b0;
    step();
    total++;
    if (obs_d.size() - rd_d != 2 || obs_t.size() - rd_t != 1) begin
      bad++;
      $display("FAIL abort_writes: got dram=%0d tag=%0d, required dram=2 tag=1",
               obs_d.size() - rd_d, obs_t.size() - rd_t);
    end
    // Abort writes are drained by the scoreboard inside the next refill.
    run_refill(32'h0000_1234, 1, 1, 32'h0000_00D0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef ICACHE_FLUSH_EN
  task automatic test_flush();
    int d0, lim;
    tw_t t;
    for (int i = 0; i < (1 << IRW); i++) exp_t.push_back('{a: IRW'(i), d: '0});
    d0 = done_cnt;
    miss_adr  = 32'h0123_4560;
    miss_req  = 1'b1;
    flush_req = 1'b1;
    step();
    miss_req  = 1'b0;
    flush_req = 1'b0;
    lim = 0;
    while (done_cnt == d0 && lim < 100) begin
      step();
      lim++;
    end
    step();
    total++;
    if (lim >= 100 || done_adr !== '1 || refill_busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_done: got waited=%0d adr=%h busy=%b, required adr=%h busy=0",
               lim, done_adr, refill_busy, {IRW{1'b1}});
    end
    while (exp_t.size() > 0) begin
      t = exp_t.pop_front();
      total++;
      if (rd_t >= obs_t.size()) begin
        bad++;
        $display("FAIL flush_write: got none, required adr=%h data=%h", t.a, t.d);
      end else begin
        if (obs_t[rd_t] !== t) begin
          bad++;
          $display("FAIL flush_write: got adr=%h data=%h, required adr=%h data=%h",
                   obs_t[rd_t].a, obs_t[rd_t].d, t.a, t.d);
        end
        rd_t++;
      end
    end
    total++;
    if (obs_t.size() != rd_t || obs_d.size() != rd_d) begin
      bad++;
      $display("FAIL flush_extra: got tag=%0d dram=%0d surplus, required 0 and 0",
               obs_t.size() - rd_t, obs_d.size() - rd_d);
    end
    rd_t = obs_t.size();
    run_refill(32'h0765_4320, 0, 1, 32'h0000_00E0, 1'b0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ack_gap();
    test_ignored();
    test_reset_abort();
`ifdef ICACHE_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
